// File: rtl/imem_loadable.sv
// imem_loadable: instruction memory that clears itself to NOP, accepts a streamed program,
// then serves registered fetches with misalignment and out-of-range fault substitution.
module imem_loadable #(
   parameter int INS_WIDTH = 32,
   parameter int INS_DEPTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter logic [INS_WIDTH-1:0] NOP_WORD = 32'h00000013
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ld_valid,
   output logic                         ld_ready,
   input  logic [INS_WIDTH-1:0]         ld_data,
   input  logic                         ld_last,
   input  logic                         fetch_en,
   input  logic [ADDR_WIDTH-1:0]        fetch_addr,
   output logic [INS_WIDTH-1:0]         instruction_out,
   output logic                         inst_valid,
   output logic                         fault,
   output logic                         mem_ready,
   output logic [$clog2(INS_DEPTH):0]   load_count
);
   localparam int AW = $clog2(INS_DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;
   state_t state;
   logic [INS_WIDTH-1:0] mem [INS_DEPTH];
   logic [AW-1:0] clr_ptr, ld_ptr;
   logic [ADDR_WIDTH-3:0] idx;
   logic bad, accept, done, serve;
   assign idx = fetch_addr[ADDR_WIDTH-1:2];
   // the range check uses every index bit so high addresses never alias onto low words
   assign bad = (fetch_addr[1:0] != 2'b00) || (idx >= (ADDR_WIDTH-2)'(INS_DEPTH));
   assign accept = reset && state == LOAD && ld_valid && ld_ready;
   assign done = ld_last || ld_ptr == '1;
   assign serve = state == RUN && fetch_en;
   always_ff @(posedge clk) begin
      if (reset && state == CLEAR) mem[clr_ptr] <= NOP_WORD;
      else if (accept) mem[ld_ptr] <= ld_data;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= CLEAR;
         clr_ptr <= '0;
         ld_ptr <= '0;
         ld_ready <= 1'b0;
         instruction_out <= NOP_WORD;
         inst_valid <= 1'b0;
         fault <= 1'b0;
         mem_ready <= 1'b0;
         load_count <= '0;
      end else begin
         inst_valid <= serve;
         fault <= serve && bad;
         if (serve) instruction_out <= bad ? NOP_WORD : mem[idx[AW-1:0]];
         if (state == CLEAR) begin
            clr_ptr <= clr_ptr + AW'(1);
            if (clr_ptr == '1) begin
               state <= LOAD;
               ld_ready <= 1'b1;
            end
         end
         if (accept) begin
            ld_ptr <= ld_ptr + AW'(1);
            load_count <= load_count + CW'(1);
            if (done) begin
               state <= RUN;
               ld_ready <= 1'b0;
               mem_ready <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: vector table, directed phase sequences and randomized fetches against an array model.
module tb_imem_loadable;
   localparam logic [31:0] NOP = 32'h00000013;
   logic clk = 1'b0, reset = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, fetch_en = 1'b0;
   logic [31:0] ld_data = '0, fetch_addr = '0;
   logic ld_ready, inst_valid, fault, mem_ready;
   logic [31:0] instruction_out;
   logic [6:0] load_count;
   int checks = 0, errors = 0, cnt = 0;
   logic [31:0] model_mem [64];
   logic [31:0] held;
   typedef struct {
      logic fe;
      logic [31:0] addr;
      logic v;
      logic f;
      logic [31:0] ins;
   } vec_t;
   vec_t vt[14];

   imem_loadable dut (
      .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .ld_last(ld_last), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
      .instruction_out(instruction_out), .inst_valid(inst_valid), .fault(fault),
      .mem_ready(mem_ready), .load_count(load_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_mem_ready", mem_ready, 0);
      chk("rst_instr", instruction_out, NOP);
      chk("rst_valid", inst_valid, 0);
      chk("rst_fault", fault, 0);
      chk("rst_count", load_count, 0);
      reset = 1'b1;
      cnt = 0;
      for (int i = 0; i < 64; i++) model_mem[i] = NOP;
   endtask

   task automatic wait_clear();
      int n = 0;
      while (!ld_ready && n < 200) begin
         step();
         n++;
         chk("clear_mem_ready", mem_ready, 0);
         chk("clear_valid", inst_valid, 0);
         chk("clear_instr", instruction_out, NOP);
      end
      chk("clear_len", n, 64);
   endtask

   task automatic load(input logic [31:0] d, input bit last);
      chk("ld_ready_before", ld_ready, 1);
      ld_valid = 1'b1;
      ld_data = d;
      ld_last = last;
      step();
      ld_valid = 1'b0;
      ld_last = 1'b0;
      model_mem[cnt] = d;
      cnt++;
      chk("ld_count", load_count, cnt);
      chk("ld_valid_out", inst_valid, 0);
      chk("ld_mem_ready", mem_ready, (last || cnt == 64) ? 1 : 0);
   endtask

   task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] exp, input bit f);
      fetch_en = 1'b1;
      fetch_addr = a;
      step();
      chk({name, "_valid"}, inst_valid, 1);
      chk({name, "_fault"}, fault, f);
      chk({name, "_instr"}, instruction_out, exp);
      held = exp;
   endtask

   task automatic rand_fetch(input int n);
      for (int k = 0; k < n; k++) begin
         logic fe, v, f;
         logic [31:0] a, e;
         int r;
         fe = (k == 0) || ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 9);
         a = (r < 6) ? 32'($urandom_range(0, 63) * 4) : (r < 8) ? $urandom : 32'($urandom_range(0, 255));
         fetch_en = fe;
         fetch_addr = a;
         ld_valid = $urandom_range(0, 1) == 1;
         ld_data = $urandom;
         ld_last = $urandom_range(0, 1) == 1;
         if (fe) begin
            f = (a % 4 != 0) || (a / 4 >= 64);
            e = f ? NOP : model_mem[a / 4];
            v = 1'b1;
            held = e;
         end else begin
            f = 1'b0;
            v = 1'b0;
            e = held;
         end
         step();
         chk("rnd_valid", inst_valid, v);
         chk("rnd_fault", fault, f);
         chk("rnd_instr", instruction_out, e);
         chk("rnd_count", load_count, cnt);
         chk("rnd_ld_ready", ld_ready, 0);
      end
      ld_valid = 1'b0;
      ld_last = 1'b0;
   endtask

   initial begin
      vt[0]  = '{1'b1, 32'h0,        1'b1, 1'b0, 32'h00200113};
      vt[1]  = '{1'b1, 32'h4,        1'b1, 1'b0, 32'h00C00193};
      vt[2]  = '{1'b1, 32'h8,        1'b1, 1'b0, 32'h403100B3};
      vt[3]  = '{1'b1, 32'hC,        1'b1, 1'b0, NOP};
      vt[4]  = '{1'b1, 32'h2,        1'b1, 1'b1, NOP};
      vt[5]  = '{1'b1, 32'h100,      1'b1, 1'b1, NOP};
      vt[6]  = '{1'b0, 32'h4,        1'b0, 1'b0, NOP};
      vt[7]  = '{1'b1, 32'h4,        1'b1, 1'b0, 32'h00C00193};
      vt[8]  = '{1'b0, 32'h8,        1'b0, 1'b0, 32'h00C00193};
      vt[9]  = '{1'b1, 32'hFFFFFF00, 1'b1, 1'b1, NOP};
      vt[10] = '{1'b1, 32'h80000008, 1'b1, 1'b1, NOP};
      vt[11] = '{1'b1, 32'h8,        1'b1, 1'b0, 32'h403100B3};
      vt[12] = '{1'b1, 32'hFC,       1'b1, 1'b0, NOP};
      vt[13] = '{1'b1, 32'h9,        1'b1, 1'b1, NOP};

      fetch_en = 1'b1;
      fetch_addr = 32'h0;
      do_reset();
      wait_clear();
      chk("load_mem_ready", mem_ready, 0);
      ld_last = 1'b1;
      step();
      ld_last = 1'b0;
      chk("ghost_last_ready", ld_ready, 1);
      chk("ghost_last_run", mem_ready, 0);
      chk("ghost_last_count", load_count, 0);
      load(32'h00200113, 1'b0);
      load(32'h00C00193, 1'b0);
      load(32'h403100B3, 1'b1);
      chk("run_ld_ready", ld_ready, 0);
      chk("run_entry_valid", inst_valid, 0);
      step();
      chk("first_resp_valid", inst_valid, 1);
      chk("first_resp_instr", instruction_out, 32'h00200113);
      for (int i = 0; i < 14; i++) begin
         fetch_en = vt[i].fe;
         fetch_addr = vt[i].addr;
         step();
         chk($sformatf("vec%0d_valid", i), inst_valid, vt[i].v);
         chk($sformatf("vec%0d_fault", i), fault, vt[i].f);
         chk($sformatf("vec%0d_instr", i), instruction_out, vt[i].ins);
         chk($sformatf("vec%0d_count", i), load_count, 3);
      end
      rand_fetch(150);

      do_reset();
      wait_clear();
      for (int i = 0; i < 64; i++) begin
         if (i == 10 || i == 40) begin
            step();
            chk("gap_count", load_count, i);
         end
         load(32'(i), 1'b0);
      end
      chk("full_ld_ready", ld_ready, 0);
      chk("full_count", load_count, 64);
      ld_valid = 1'b1;
      ld_data = 32'hBADBAD00;
      fetch_en = 1'b0;
      step();
      ld_valid = 1'b0;
      chk("extra_count", load_count, 64);
      chk("extra_ready", ld_ready, 0);
      fetch("full_fc", 32'hFC, 32'h3F, 1'b0);
      fetch("full_0", 32'h0, 32'h0, 1'b0);
      rand_fetch(150);

      fetch_en = 1'b1;
      fetch_addr = 32'h0;
      do_reset();
      wait_clear();
      for (int i = 0; i < 5; i++) load($urandom, 1'b0);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("midload_rst_ready", ld_ready, 0);
      chk("midload_rst_count", load_count, 0);
      cnt = 0;
      for (int i = 0; i < 64; i++) model_mem[i] = NOP;
      wait_clear();
      load(32'hDEADBEEF, 1'b1);
      chk("reload_count", load_count, 1);
      fetch("reload_0", 32'h0, 32'hDEADBEEF, 1'b0);
      fetch("reload_4", 32'h4, NOP, 1'b0);
      rand_fetch(100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
